// File: rtl/eth_udp_datagram.sv
// IPv4/UDP datagram builder: 20-byte IPv4 header, 8-byte UDP header, then payload, as a byte stream.
// Optional macro ETH_MIN_PAD_EN: zero-pad datagrams shorter than 46 bytes up to the Ethernet minimum.
module eth_udp_datagram #(
   parameter logic [7:0]  TTL         = 8'd64,
   parameter int          PAYLOAD_MAX = 1472,
   parameter logic [15:0] ID_INIT     = 16'h0000
) (
   input  logic        s_axis_aclk,
   input  logic        s_axis_aresetn,
   input  logic [31:0] src_ip,
   input  logic [31:0] dst_ip,
   input  logic [15:0] src_port,
   input  logic [15:0] dst_port,
   input  logic [15:0] payload_len,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic        err_len,
   input  logic [7:0]  pl_axis_tdata,
   input  logic        pl_axis_tvalid,
   output logic        pl_axis_tready,
   input  logic        pl_axis_tlast,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser
);

   localparam logic [15:0] PMAX = 16'(PAYLOAD_MAX);

   typedef enum logic [2:0] {IDLE, CSUM, HEAD, DATA, PAD, DRAIN, FIN} state_t;
   state_t state, state_nxt;

   logic [31:0] sip, dip;
   logic [15:0] sport, dport, tot_len, udp_len, id, csum;
   logic [19:0] acc;
   logic [3:0]  cnt;
   logic [4:0]  hidx;
   logic [15:0] rem, pl_rem, body_len, word;
   logic        pl_done;
   logic [16:0] fold1;
   logic [15:0] fold2;
   logic [7:0]  hdr_byte;
   logic        accept, len_bad, adv, pl_xfer;
   logic        ld, ld_last, ld_user;
   logic [7:0]  ld_data;

   assign accept  = (state == IDLE) & cmd_valid & cmd_ready;
   assign len_bad = payload_len > PMAX;
   // The output register can take a new beat when empty or when its beat moves this cycle.
   assign adv     = ~m_axis_tvalid | m_axis_tready;
   assign pl_axis_tready = ((state == DATA) & adv) | (state == DRAIN);
   assign pl_xfer = pl_axis_tvalid & pl_axis_tready;

`ifdef ETH_MIN_PAD_EN
   assign body_len = (payload_len < 16'd18) ? 16'd18 : payload_len;
`else
   assign body_len = payload_len;
`endif

   always_comb begin
      case (cnt)
         4'd0:    word = 16'h4500;
         4'd1:    word = tot_len;
         4'd2:    word = id;
         4'd3:    word = 16'h4000;
         4'd4:    word = {TTL, 8'h11};
         4'd5:    word = sip[31:16];
         4'd6:    word = sip[15:0];
         4'd7:    word = dip[31:16];
         default: word = dip[15:0];
      endcase
   end

   // Two folds are enough: the first leaves at most a single carry bit.
   assign fold1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
   assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

   always_comb begin
      case (hidx)
         5'd0:    hdr_byte = 8'h45;
         5'd2:    hdr_byte = tot_len[15:8];
         5'd3:    hdr_byte = tot_len[7:0];
         5'd4:    hdr_byte = id[15:8];
         5'd5:    hdr_byte = id[7:0];
         5'd6:    hdr_byte = 8'h40;
         5'd8:    hdr_byte = TTL;
         5'd9:    hdr_byte = 8'h11;
         5'd10:   hdr_byte = csum[15:8];
         5'd11:   hdr_byte = csum[7:0];
         5'd12:   hdr_byte = sip[31:24];
         5'd13:   hdr_byte = sip[23:16];
         5'd14:   hdr_byte = sip[15:8];
         5'd15:   hdr_byte = sip[7:0];
         5'd16:   hdr_byte = dip[31:24];
         5'd17:   hdr_byte = dip[23:16];
         5'd18:   hdr_byte = dip[15:8];
         5'd19:   hdr_byte = dip[7:0];
         5'd20:   hdr_byte = sport[15:8];
         5'd21:   hdr_byte = sport[7:0];
         5'd22:   hdr_byte = dport[15:8];
         5'd23:   hdr_byte = dport[7:0];
         5'd24:   hdr_byte = udp_len[15:8];
         5'd25:   hdr_byte = udp_len[7:0];
         default: hdr_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_nxt = state;
      ld        = 1'b0;
      ld_data   = 8'h00;
      ld_last   = 1'b0;
      ld_user   = 1'b0;
      case (state)
         IDLE: if (accept && !len_bad) state_nxt = CSUM;
         CSUM: if (cnt == 4'd9) state_nxt = HEAD;
         HEAD: if (adv) begin
            ld      = 1'b1;
            ld_data = hdr_byte;
            ld_user = (hidx == 5'd0);
            ld_last = (hidx == 5'd27) && (rem == 16'd0);
            if (hidx == 5'd27)
               state_nxt = (rem == 16'd0) ? FIN : (pl_rem == 16'd0) ? PAD : DATA;
         end
         DATA: if (pl_xfer) begin
            ld      = 1'b1;
            ld_data = pl_axis_tdata;
            ld_last = (rem == 16'd1);
            if (rem == 16'd1)
               state_nxt = pl_axis_tlast ? FIN : DRAIN;
            else if (pl_axis_tlast || pl_rem == 16'd1)
               state_nxt = PAD;
         end
         PAD: if (adv) begin
            ld      = 1'b1;
            ld_last = (rem == 16'd1);
            if (rem == 16'd1) state_nxt = pl_done ? FIN : DRAIN;
         end
         DRAIN: if (pl_xfer && pl_axis_tlast) state_nxt = FIN;
         FIN:   if (adv) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         state         <= IDLE;
         cmd_ready     <= 1'b0;
         err_len       <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= 8'h00;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         id            <= ID_INIT;
         sip           <= '0;
         dip           <= '0;
         sport         <= '0;
         dport         <= '0;
         tot_len       <= '0;
         udp_len       <= '0;
         csum          <= '0;
         acc           <= '0;
         cnt           <= '0;
         hidx          <= '0;
         rem           <= '0;
         pl_rem        <= '0;
         pl_done       <= 1'b0;
      end else begin
         state     <= state_nxt;
         cmd_ready <= (state_nxt == IDLE);
         err_len   <= accept & len_bad;
         if (accept && !len_bad) begin
            sip     <= src_ip;
            dip     <= dst_ip;
            sport   <= src_port;
            dport   <= dst_port;
            tot_len <= payload_len + 16'd28;
            udp_len <= payload_len + 16'd8;
            rem     <= body_len;
            pl_rem  <= payload_len;
            pl_done <= (payload_len == 16'd0);
            acc     <= '0;
            cnt     <= '0;
            hidx    <= '0;
         end
         if (state == CSUM) begin
            if (cnt == 4'd9) csum <= ~fold2;
            else             acc  <= acc + {4'd0, word};
            cnt <= cnt + 4'd1;
         end
         if (state == HEAD && adv) hidx <= hidx + 5'd1;
         if (ld && (state == DATA || state == PAD)) rem <= rem - 16'd1;
         if (state == DATA && pl_xfer) begin
            pl_rem  <= pl_rem - 16'd1;
            pl_done <= pl_axis_tlast;
         end
         if (adv) begin
            m_axis_tvalid <= ld;
            m_axis_tdata  <= ld_data;
            m_axis_tlast  <= ld_last;
            m_axis_tuser  <= ld_user;
         end
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast) id <= id + 16'd1;
      end
   end

endmodule

// File: tb/tb_eth_udp_datagram.sv
// Directed bench for eth_udp_datagram: two instances (ID_INIT 0 and FFFF) sharing stimulus, muxed by sel.
module tb_eth_udp_datagram;

`ifdef ETH_MIN_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, cmd_valid, sel;
   logic [31:0] src_ip, dst_ip;
   logic [15:0] src_port, dst_port, payload_len;
   logic [7:0]  pl_tdata;
   logic        pl_tvalid, pl_tlast, m_tready;

   logic        a_cmd_ready, a_err, a_pl_tready, a_tvalid, a_tlast, a_tuser;
   logic [7:0]  a_tdata;
   logic        b_cmd_ready, b_err, b_pl_tready, b_tvalid, b_tlast, b_tuser;
   logic [7:0]  b_tdata;
   logic        cmd_ready, err_len, pl_tready, tvalid, tlast, tuser;
   logic [7:0]  tdata;

   assign cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
   assign err_len   = sel ? b_err       : a_err;
   assign pl_tready = sel ? b_pl_tready : a_pl_tready;
   assign tvalid    = sel ? b_tvalid    : a_tvalid;
   assign tlast     = sel ? b_tlast     : a_tlast;
   assign tuser     = sel ? b_tuser     : a_tuser;
   assign tdata     = sel ? b_tdata     : a_tdata;

   eth_udp_datagram u_dut (
      .s_axis_aclk(clk), .s_axis_aresetn(rstn), .src_ip(src_ip), .dst_ip(dst_ip),
      .src_port(src_port), .dst_port(dst_port), .payload_len(payload_len),
      .cmd_valid(cmd_valid & ~sel), .cmd_ready(a_cmd_ready), .err_len(a_err),
      .pl_axis_tdata(pl_tdata), .pl_axis_tvalid(pl_tvalid), .pl_axis_tready(a_pl_tready),
      .pl_axis_tlast(pl_tlast), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser));

   eth_udp_datagram #(.ID_INIT(16'hFFFF)) u_wrap (
      .s_axis_aclk(clk), .s_axis_aresetn(rstn), .src_ip(src_ip), .dst_ip(dst_ip),
      .src_port(src_port), .dst_port(dst_port), .payload_len(payload_len),
      .cmd_valid(cmd_valid & sel), .cmd_ready(b_cmd_ready), .err_len(b_err),
      .pl_axis_tdata(pl_tdata), .pl_axis_tvalid(pl_tvalid), .pl_axis_tready(b_pl_tready),
      .pl_axis_tlast(pl_tlast), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser));

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit done;
      int first_e, nb, last_at, exp_n, ni;
      int byte_bad, bad_at, user_bad, hold_bad;
      logic [7:0] bad_got, bad_exp;
      bit rdy_after;
   } res_t;

   task automatic issue(input logic [15:0] len);
      @(negedge clk);
      src_ip = 32'hC0A8010A; dst_ip = 32'hC0A80114;
      src_port = 16'd1234; dst_port = 16'd5678;
      payload_len = len; cmd_valid = 1'b1;
   endtask

   // Drives one datagram (payload bytes A0,A1,..) and records what comes out; no judging here.
   task automatic capture(input logic [15:0] len, input int n_in, input logic [15:0] tot,
                          input logic [15:0] id, input logic [15:0] cs, input logic [15:0] udp,
                          input bit stall, output res_t r);
      logic [7:0] hdr [0:27];
      logic [7:0] exp_b [0:63];
      logic [7:0] pd;
      logic pl, pu, prev_stall;
      int e;
      hdr = '{8'h45, 8'h00, tot[15:8], tot[7:0], id[15:8], id[7:0], 8'h40, 8'h00,
              8'h40, 8'h11, cs[15:8], cs[7:0], 8'hC0, 8'hA8, 8'h01, 8'h0A,
              8'hC0, 8'hA8, 8'h01, 8'h14, 8'h04, 8'hD2, 8'h16, 8'h2E,
              udp[15:8], udp[7:0], 8'h00, 8'h00};
      r = '{default: 0};
      r.first_e = -1; r.last_at = -1; r.bad_at = -1;
      r.exp_n = 28 + int'(len);
      if (PAD_EN && len < 16'd18) r.exp_n = 46;
      for (int i = 0; i < 64; i++) begin
         if (i < 28) exp_b[i] = hdr[i];
         else if (i - 28 < int'(len) && i - 28 < n_in) exp_b[i] = 8'(160 + i - 28);
         else exp_b[i] = 8'h00;
      end
      issue(len);
      prev_stall = 1'b0; pd = 8'h00; pl = 1'b0; pu = 1'b0;
      e = 0;
      while (e < 400 && !r.done) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         m_tready = stall ? ((e % 4 == 0) || (e % 4 == 3)) : 1'b1;
         if (r.ni < n_in) begin
            pl_tvalid = 1'b1; pl_tdata = 8'(160 + r.ni); pl_tlast = (r.ni == n_in - 1);
         end else begin
            pl_tvalid = 1'b0; pl_tlast = 1'b0;
         end
         #1;
         if (prev_stall && !(tvalid === 1'b1 && tdata === pd && tlast === pl && tuser === pu))
            r.hold_bad++;
         if (tvalid === 1'b1 && r.first_e < 0) r.first_e = e;
         if (tvalid === 1'b1 && m_tready) begin
            if (r.nb < 64 && tdata !== exp_b[r.nb]) begin
               if (r.bad_at < 0) begin
                  r.bad_at = r.nb; r.bad_got = tdata; r.bad_exp = exp_b[r.nb];
               end
               r.byte_bad++;
            end
            if (tuser !== (r.nb == 0)) r.user_bad++;
            r.nb++;
            if (tlast === 1'b1 && r.last_at < 0) r.last_at = r.nb;
         end
         if (pl_tvalid && pl_tready === 1'b1) r.ni++;
         prev_stall = (tvalid === 1'b1) && !m_tready;
         pd = tdata; pl = tlast; pu = tuser;
         e++;
         r.done = (r.last_at > 0) && (r.ni >= n_in);
      end
      for (int k = 0; k < 6 && !r.rdy_after; k++) begin
         @(negedge clk);
         pl_tvalid = 1'b0; pl_tlast = 1'b0; m_tready = 1'b1;
         #1 r.rdy_after = (cmd_ready === 1'b1);
      end
   endtask

   task automatic test_reset;
      rstn = 1'b0; sel = 1'b0; cmd_valid = 1'b0; m_tready = 1'b1;
      pl_tvalid = 1'b0; pl_tlast = 1'b0; pl_tdata = 8'h00;
      src_ip = '0; dst_ip = '0; src_port = '0; dst_port = '0; payload_len = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({a_tvalid, a_tlast, a_tuser, a_tdata, a_pl_tready, a_err, a_cmd_ready} !== 14'd0) begin
         errors++;
         $display("FAIL reset_outputs: got tv=%b tl=%b tu=%b td=%02h plr=%b err=%b rdy=%b want all 0",
                  a_tvalid, a_tlast, a_tuser, a_tdata, a_pl_tready, a_err, a_cmd_ready);
      end
      @(negedge clk) rstn = 1'b1;
      @(negedge clk) #1;
      checks++;
      if (a_cmd_ready !== 1'b1 || b_cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b/%b want 1/1", a_cmd_ready, b_cmd_ready);
      end
   endtask

   task automatic test_bad_len;
      int pulses, tv_seen;
      issue(16'd1473);
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      checks++;
      if (err_len !== 1'b1) begin
         errors++; $display("FAIL bad_len_err: got %b want 1", err_len);
      end
      pulses = 0; tv_seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk) #1;
         if (err_len === 1'b1) pulses++;
         if (tvalid !== 1'b0) tv_seen++;
      end
      checks++;
      if (pulses != 0) begin
         errors++; $display("FAIL bad_len_pulse_width: extra pulses %0d want 0", pulses);
      end
      checks++;
      if (tv_seen != 0) begin
         errors++; $display("FAIL bad_len_no_output: tvalid cycles %0d want 0", tv_seen);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL bad_len_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_basic(input logic [15:0] id, input logic [15:0] cs);
      res_t r;
      capture(16'd4, 4, 16'h0020, id, cs, 16'h000C, 1'b0, r);
      checks++;
      if (!r.done) begin errors++; $display("FAIL basic_timeout: beats %0d in %0d", r.nb, r.ni); end
      checks++;
      if (r.first_e != 11) begin errors++; $display("FAIL basic_latency: got %0d want 11", r.first_e); end
      checks++;
      if (r.byte_bad != 0) begin
         errors++;
         $display("FAIL basic_bytes: %0d bad, beat %0d got %02h want %02h", r.byte_bad, r.bad_at, r.bad_got, r.bad_exp);
      end
      checks++;
      if (r.user_bad != 0) begin errors++; $display("FAIL basic_tuser: %0d bad beats want 0", r.user_bad); end
      checks++;
      if (r.last_at != r.exp_n) begin errors++; $display("FAIL basic_tlast: got beat %0d want %0d", r.last_at, r.exp_n); end
      checks++;
      if (r.nb != r.exp_n) begin errors++; $display("FAIL basic_beats: got %0d want %0d", r.nb, r.exp_n); end
      checks++;
      if (!r.rdy_after) begin errors++; $display("FAIL basic_ready_after: got 0 want 1"); end
   endtask

   task automatic test_backpressure;
      res_t r;
      capture(16'd4, 4, 16'h0020, 16'h0001, 16'hB75D, 16'h000C, 1'b1, r);
      checks++;
      if (!r.done) begin errors++; $display("FAIL bp_timeout: beats %0d", r.nb); end
      checks++;
      if (r.byte_bad != 0) begin
         errors++;
         $display("FAIL bp_bytes: %0d bad, beat %0d got %02h want %02h", r.byte_bad, r.bad_at, r.bad_got, r.bad_exp);
      end
      checks++;
      if (r.hold_bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable stalls want 0", r.hold_bad); end
      checks++;
      if (r.last_at != r.exp_n) begin errors++; $display("FAIL bp_tlast: got beat %0d want %0d", r.last_at, r.exp_n); end
   endtask

   task automatic test_early_tlast;
      res_t r;
      capture(16'd6, 3, 16'h0022, 16'h0002, 16'hB75A, 16'h000E, 1'b0, r);
      checks++;
      if (!r.done) begin errors++; $display("FAIL early_timeout: beats %0d", r.nb); end
      checks++;
      if (r.byte_bad != 0) begin
         errors++;
         $display("FAIL early_bytes: %0d bad, beat %0d got %02h want %02h", r.byte_bad, r.bad_at, r.bad_got, r.bad_exp);
      end
      checks++;
      if (r.last_at != r.exp_n) begin errors++; $display("FAIL early_tlast: got beat %0d want %0d", r.last_at, r.exp_n); end
      checks++;
      if (r.ni != 3) begin errors++; $display("FAIL early_consumed: got %0d want 3", r.ni); end
   endtask

   task automatic test_late_tlast;
      res_t r;
      capture(16'd3, 6, 16'h001F, 16'h0003, 16'hB75C, 16'h000B, 1'b0, r);
      checks++;
      if (!r.done) begin errors++; $display("FAIL late_timeout: beats %0d in %0d", r.nb, r.ni); end
      checks++;
      if (r.byte_bad != 0) begin
         errors++;
         $display("FAIL late_bytes: %0d bad, beat %0d got %02h want %02h", r.byte_bad, r.bad_at, r.bad_got, r.bad_exp);
      end
      checks++;
      if (r.last_at != r.exp_n) begin errors++; $display("FAIL late_tlast: got beat %0d want %0d", r.last_at, r.exp_n); end
      checks++;
      if (r.ni != 6) begin errors++; $display("FAIL late_drained: got %0d want 6", r.ni); end
      checks++;
      if (!r.rdy_after) begin errors++; $display("FAIL late_ready_after: got 0 want 1"); end
   endtask

   task automatic test_zero_len;
      res_t r;
      capture(16'd0, 0, 16'h001C, 16'h0004, 16'hB75E, 16'h0008, 1'b0, r);
      checks++;
      if (r.byte_bad != 0) begin
         errors++;
         $display("FAIL zero_bytes: %0d bad, beat %0d got %02h want %02h", r.byte_bad, r.bad_at, r.bad_got, r.bad_exp);
      end
      checks++;
      if (r.last_at != r.exp_n) begin errors++; $display("FAIL zero_tlast: got beat %0d want %0d", r.last_at, r.exp_n); end
      checks++;
      if (r.user_bad != 0) begin errors++; $display("FAIL zero_tuser: %0d bad beats want 0", r.user_bad); end
   endtask

   task automatic test_id_wrap;
      res_t r;
      @(negedge clk) sel = 1'b1;
      capture(16'd0, 0, 16'h001C, 16'hFFFF, 16'hB762, 16'h0008, 1'b0, r);
      checks++;
      if (r.byte_bad != 0) begin
         errors++;
         $display("FAIL wrap_ffff_bytes: %0d bad, beat %0d got %02h want %02h", r.byte_bad, r.bad_at, r.bad_got, r.bad_exp);
      end
      checks++;
      if (r.last_at != r.exp_n) begin errors++; $display("FAIL wrap_ffff_tlast: got beat %0d want %0d", r.last_at, r.exp_n); end
      capture(16'd0, 0, 16'h001C, 16'h0000, 16'hB762, 16'h0008, 1'b0, r);
      checks++;
      if (r.byte_bad != 0) begin
         errors++;
         $display("FAIL wrap_0000_bytes: %0d bad, beat %0d got %02h want %02h", r.byte_bad, r.bad_at, r.bad_got, r.bad_exp);
      end
      checks++;
      if (r.last_at != r.exp_n) begin errors++; $display("FAIL wrap_0000_tlast: got beat %0d want %0d", r.last_at, r.exp_n); end
      @(negedge clk) sel = 1'b0;
   endtask

   task automatic test_reset_mid;
      int ni;
      ni = 0;
      issue(16'd8);
      for (int k = 0; k < 60 && ni < 2; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0; m_tready = 1'b1;
         pl_tvalid = 1'b1; pl_tdata = 8'(160 + ni); pl_tlast = 1'b0;
         #1 if (pl_tready === 1'b1) ni++;
      end
      checks++;
      if (ni != 2) begin errors++; $display("FAIL rstmid_payload: got %0d bytes want 2", ni); end
      @(negedge clk);
      rstn = 1'b0; pl_tvalid = 1'b0;
      @(negedge clk) #1;
      checks++;
      if ({a_tvalid, a_tlast, a_tuser, a_tdata, a_pl_tready, a_err, a_cmd_ready} !== 14'd0) begin
         errors++;
         $display("FAIL rstmid_outputs: got tv=%b tl=%b tu=%b td=%02h plr=%b err=%b rdy=%b want all 0",
                  a_tvalid, a_tlast, a_tuser, a_tdata, a_pl_tready, a_err, a_cmd_ready);
      end
      @(negedge clk) rstn = 1'b1;
      @(negedge clk) #1;
      checks++;
      if (a_cmd_ready !== 1'b1 || a_tvalid !== 1'b0) begin
         errors++; $display("FAIL rstmid_release: got rdy=%b tv=%b want 1/0", a_cmd_ready, a_tvalid);
      end
   endtask

   initial begin
      test_reset();
      test_bad_len();
      test_basic(16'h0000, 16'hB75E);
      test_backpressure();
      test_early_tlast();
      test_late_tlast();
      test_zero_len();
      test_id_wrap();
      test_reset_mid();
      test_basic(16'h0000, 16'hB75E);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eth_udp_datagram.md
Name: eth_udp_datagram

Overview:
Builds an IPv4/UDP datagram as a byte stream: a 20-byte IPv4 header, then an 8-byte UDP header, then the payload. It feeds the Ethernet framer directly downstream, which adds preamble, MAC header and FCS. The framer receives tuser on the first header byte and tlast on the final byte. The IPv4 header checksum is computed sequentially before the header is emitted.

Parameters:
TTL, 8'd64, IPv4 time-to-live field.
PAYLOAD_MAX, 1472, largest legal payload_len in bytes.
ID_INIT, 16'h0000, reset value of the IPv4 identification counter.

Ports:
s_axis_aclk  in  1  single clock for all logic
s_axis_aresetn  in  1  synchronous active-low reset
src_ip  in  32  source IPv4 address, sampled at command accept
dst_ip  in  32  destination IPv4 address, sampled at command accept
src_port  in  16  UDP source port, sampled at command accept
dst_port  in  16  UDP destination port, sampled at command accept
payload_len  in  16  payload byte count, sampled at command accept
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
err_len  out  1  one-cycle pulse: command rejected because payload_len > PAYLOAD_MAX
pl_axis_tdata  in  8  payload byte
pl_axis_tvalid  in  1  payload valid
pl_axis_tready  out  1  payload ready
pl_axis_tlast  in  1  last payload byte
m_axis_tdata  out  8  datagram byte to framer
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  framer ready
m_axis_tlast  out  1  final datagram byte
m_axis_tuser  out  1  first datagram byte (IPv4 byte 0)

Behaviour:
- Clock and reset: one clock, s_axis_aclk. Reset is synchronous and active-low on s_axis_aresetn.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, pl_axis_tready=0, err_len=0, cmd_ready=0, ID counter=ID_INIT, state=IDLE.
- Reset mid-operation: the datagram is abandoned with no tlast; the next cycle after reset deasserts is IDLE.
- Output handshake: a beat transfers on m_axis_tvalid & m_axis_tready. While tvalid=1 and tready=0, tdata, tlast and tuser are held stable. tvalid never drops before its beat transfers.
- State IDLE:
  - cmd_ready=1.
  - On accept with payload_len > PAYLOAD_MAX: pulse err_len for one cycle, stay in IDLE, emit nothing, ID counter unchanged.
  - On accept otherwise: latch all fields, tot_len = payload_len+28, udp_len = payload_len+8, go to CSUM. cmd_ready=0 outside IDLE.
- State CSUM:
  - Nine cycles, one 16-bit word added per cycle into a 20-bit accumulator, in this order: 16'h4500, tot_len, ID, 16'h4000, {TTL,8'h11}, src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0].
  - Tenth cycle: fold = acc[15:0] + acc[19:16], fold again if a carry remains, checksum = ~fold. Go to HEAD.
  - First header byte is valid 11 cycles after command accept.
- State HEAD:
  - 28 bytes, MSB first, in this order: 45 00 tot_len ID 40 00 TTL 11 checksum src_ip dst_ip src_port dst_port udp_len 00 00. The UDP checksum is 0 (disabled).
  - m_axis_tuser=1 on byte 0 only.
  - If payload_len=0: tlast on byte 27, then the ID counter increments and the state returns to IDLE.
  - Otherwise go to DATA after byte 27 transfers.
- State DATA:
  - pl_axis_tready = m_axis_tready | ~m_axis_tvalid, registered pass-through. A byte counter counts down from payload_len.
  - m_axis_tlast is asserted on payload byte payload_len, regardless of pl_axis_tlast.
- Early pl_axis_tlast (input ends short of payload_len): pl_axis_tready=0 from then on, and the remaining bytes are emitted as 8'h00 (PAD state), with tlast on the final byte.
- Late pl_axis_tlast (input exceeds payload_len): after the final output byte, enter DRAIN. In DRAIN, pl_axis_tready=1 and m_axis_tvalid=0 until pl_axis_tlast is accepted; excess bytes are discarded.
- End of datagram: ID increments modulo 2^16 after tlast transfers (FFFF wraps to 0000), and the state returns to IDLE.

Optional Feature:
ETH_MIN_PAD_EN
- Defined: if payload_len < 18, append 8'h00 bytes after the payload until 46 bytes total have been emitted, so the Ethernet frame reaches the 64-byte minimum. tlast is on byte 46. tot_len and udp_len still reflect the real payload_len.
- Undefined: no padding; tlast is on byte 28+payload_len.

Test Plan:
- Basic datagram: src 192.168.1.10, dst 192.168.1.20, ports 1234->5678, len 4, ID 0, TTL 64.
  - Required: checksum B75E, tot_len 0020, udp_len 000C, tuser on byte 0.
  - Required: 32 beats, tlast on beat 32.
  - Required: first valid 11 cycles after accept.
- Backpressure: m_axis_tready toggled 1-0-0-1 through header and payload -> byte sequence identical to the no-stall case; data held stable during stalls.
- Bad length: payload_len=1473 -> err_len pulses once, no m_axis_tvalid, next command uses ID 0.
- tlast mismatches:
  - len 6 with pl tlast on byte 3 -> bytes 4-6 output as 00, tlast on byte 6.
  - len 3 with 6 input bytes -> 3 bytes output, 3 drained, next command accepted afterwards.
- Zero length and ID wrap: len 0 -> 28 beats, tlast on byte 27. Two datagrams starting at ID FFFF -> ID fields FFFF then 0000.
- Reset and padding:
  - s_axis_aresetn low mid-payload -> all outputs 0 the next cycle, cmd_ready=1 one cycle after release.
  - With ETH_MIN_PAD_EN, len 4 -> 46 beats, tot_len still 0020.
